mi3_pio_arbiter: RTL and testbench

MI3_PIO_ARBITER -- requirements
Module: mi3_pio_arbiter

---
 rtl/mi3_pio_arbiter.sv | 127 ++++++++++++
 tb/tb_mi3_pio_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mi3_pio_arbiter.sv
// rtl/mi3_pio_arbiter.sv - two-requester round-robin arbiter in front of a shared zero-latency PIO slave
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   m0_* / m1_*  (chipselect, write_n, address, writedata in; waitrequest, readdata out)
//                                     requester interfaces; waitrequest low for the single completing cycle
//   s_chipselect, s_write_n, s_address, s_writedata (out), s_readdata (in)
//                                     shared PIO slave, combinational read data
//   grant                             one-hot owner of the slave during a transfer cycle
module mi3_pio_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   last_grant_nxt;
    // Cleared by reset and set by the first edge afterwards, so the earliest
    // grant lands on the second rising edge after reset is released.
    logic   armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            armed      <= 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (armed) begin
                    if (m0_chipselect && m1_chipselect) begin
                        // Contention: the requester that was not served last wins.
                        if (last_grant) begin
                            state_nxt      = XFER0;
                            last_grant_nxt = 1'b0;
                        end else begin
                            state_nxt      = XFER1;
                            last_grant_nxt = 1'b1;
                        end
                    end else if (m0_chipselect) begin
                        state_nxt      = XFER0;
                        last_grant_nxt = 1'b0;
                    end else if (m1_chipselect) begin
                        state_nxt      = XFER1;
                        last_grant_nxt = 1'b1;
                    end
                end
            end
            XFER0:   state_nxt = IDLE;
            XFER1:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The slave is driven straight from the owner's inputs, so a requester
    // dropping chipselect mid-transfer also drops s_chipselect that cycle.
    always_comb begin
        s_chipselect   = 1'b0;
        s_write_n      = 1'b1;
        s_address      = '0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        grant          = 2'b00;
        case (state)
            XFER0: begin
                s_chipselect   = m0_chipselect;
                s_write_n      = m0_write_n;
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                m0_waitrequest = 1'b0;
                m0_readdata    = s_readdata;
                grant          = 2'b01;
            end
            XFER1: begin
                s_chipselect   = m1_chipselect;
                s_write_n      = m1_write_n;
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                m1_waitrequest = 1'b0;
                m1_readdata    = s_readdata;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mi3_pio_arbiter.sv
// tb/tb_mi3_pio_arbiter.sv - self-checking bench for mi3_pio_arbiter
module tb_mi3_pio_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_chipselect = 1'b0, m0_write_n = 1'b1;
    logic [1:0]  m0_address = '0;
    logic [31:0] m0_writedata = '0;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m1_chipselect = 1'b0, m1_write_n = 1'b1;
    logic [1:0]  m1_address = '0;
    logic [31:0] m1_writedata = '0;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        s_chipselect, s_write_n;
    logic [1:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata = '0;
    logic [1:0]  grant;

    mi3_pio_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_chipselect(m0_chipselect), .m0_write_n(m0_write_n), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_chipselect(m1_chipselect), .m1_write_n(m1_write_n), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_chipselect(s_chipselect), .s_write_n(s_write_n), .s_address(s_address),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .grant(grant)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        logic        m0_cs, m0_wn;
        logic [1:0]  m0_a;
        logic [31:0] m0_wd;
        logic        m1_cs, m1_wn;
        logic [1:0]  m1_a;
        logic [31:0] m1_wd;
        logic [31:0] s_rd;
        logic [1:0]  e_grant;
        logic        e_scs, e_swn;
        logic [1:0]  e_sa;
        logic [31:0] e_swd;
        logic        e_w0, e_w1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t vecs[17];

    // Reference model state for the random phase.
    int owner;   // -1 idle, else index of the requester in transfer
    int last;
    int edges;

    task automatic drive(input logic c0, w0, input logic [1:0] a0, input logic [31:0] d0,
                         input logic c1, w1, input logic [1:0] a1, input logic [31:0] d1,
                         input logic [31:0] rd);
        m0_chipselect = c0; m0_write_n = w0; m0_address = a0; m0_writedata = d0;
        m1_chipselect = c1; m1_write_n = w1; m1_address = a1; m1_writedata = d1;
        s_readdata = rd;
    endtask

    initial begin
        int n01, n10, nscs, alt_err, prev, first, cyc;
        bit got;

        // rst, m0{cs,wn,a,wd}, m1{cs,wn,a,wd}, s_rd | grant, scs, swn, sa, swd, w0, w1, rd0, rd1
        vecs[0]  = '{1, 1,0,0,1,      0,1,0,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[1]  = '{0, 1,0,0,1,      0,1,0,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[2]  = '{0, 1,0,0,1,      0,1,0,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[3]  = '{0, 1,0,0,1,      0,1,0,0,      'h77,  1,1,0,0,1,      0,1,'h77,0};
        vecs[4]  = '{0, 0,1,0,0,      0,1,0,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[5]  = '{1, 1,0,1,1,      1,0,2,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[6]  = '{0, 1,0,1,1,      1,0,2,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[7]  = '{0, 1,0,1,1,      1,0,2,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[8]  = '{0, 1,0,1,1,      1,0,2,0,      0,     1,1,0,1,1,      0,1,0,0};
        vecs[9]  = '{0, 0,1,0,0,      1,0,2,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[10] = '{0, 0,1,0,0,      1,0,2,0,      0,     2,1,0,2,0,      1,0,0,0};
        vecs[11] = '{0, 0,1,0,0,      1,1,3,'h55,   'hA5,  0,0,1,0,0,      1,1,0,0};
        vecs[12] = '{0, 0,1,0,0,      1,1,3,'h55,   'hA5,  2,1,1,3,'h55,   1,0,0,'hA5};
        vecs[13] = '{0, 1,0,0,7,      1,1,1,0,      0,     0,0,1,0,0,      1,1,0,0};
        vecs[14] = '{0, 0,0,0,7,      1,1,1,0,      0,     1,0,0,0,7,      0,1,0,0};
        vecs[15] = '{0, 0,1,0,0,      1,1,1,0,      'h3C,  0,0,1,0,0,      1,1,0,0};
        vecs[16] = '{0, 0,1,0,0,      1,1,1,0,      'h3C,  2,1,1,1,0,      1,0,0,'h3C};

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            reset_n = !vecs[i].rst;
            drive(vecs[i].m0_cs, vecs[i].m0_wn, vecs[i].m0_a, vecs[i].m0_wd,
                  vecs[i].m1_cs, vecs[i].m1_wn, vecs[i].m1_a, vecs[i].m1_wd, vecs[i].s_rd);
            @(negedge clk);
            check($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
            check($sformatf("row%0d s_cs", i), 32'(s_chipselect), 32'(vecs[i].e_scs));
            check($sformatf("row%0d s_wn", i), 32'(s_write_n), 32'(vecs[i].e_swn));
            check($sformatf("row%0d s_addr", i), 32'(s_address), 32'(vecs[i].e_sa));
            check($sformatf("row%0d s_wdata", i), s_writedata, vecs[i].e_swd);
            check($sformatf("row%0d m0_wait", i), 32'(m0_waitrequest), 32'(vecs[i].e_w0));
            check($sformatf("row%0d m1_wait", i), 32'(m1_waitrequest), 32'(vecs[i].e_w1));
            check($sformatf("row%0d m0_rdata", i), m0_readdata, vecs[i].e_rd0);
            check($sformatf("row%0d m1_rdata", i), m1_readdata, vecs[i].e_rd1);
        end

        // Sustained contention over 16 cycles: 8 transfers alternating, m0 first.
        n01 = 0; n10 = 0; nscs = 0; alt_err = 0; prev = 0; first = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            drive(1, 0, 1, 32'h100 + 32'(c), 1, 0, 2, 32'h200 + 32'(c), 0);
            @(negedge clk);
            if (s_chipselect) nscs++;
            if (grant != 2'b00) begin
                if (first == 0) first = int'(grant);
                if (grant == prev) alt_err++;
                prev = int'(grant);
                if (grant == 2'b01) n01++;
                if (grant == 2'b10) n10++;
            end
        end
        check("contend first grant", 32'(first), 32'd1);
        check("contend m0 count", 32'(n01), 32'd4);
        check("contend m1 count", 32'(n10), 32'd4);
        check("contend alternation errors", 32'(alt_err), 32'd0);
        check("contend s_cs cycles", 32'(nscs), 32'd8);

        // Reset asserted in the middle of an XFER1 cycle.
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 1, 0, 3, 32'hDEAD, 0);
        @(posedge clk); #2;
        check("pre-reset grant", 32'(grant), 32'd2);
        check("pre-reset s_cs", 32'(s_chipselect), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset s_cs", 32'(s_chipselect), 32'd0);
        check("async reset m1_wait", 32'(m1_waitrequest), 32'd1);
        check("async reset grant", 32'(grant), 32'd0);
        check("async reset s_wdata", s_writedata, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(1, 0, 0, 32'h11, 1, 0, 1, 32'h22, 0);
        got = 0; cyc = 0;
        for (int k = 0; k < 10; k++) begin
            if (!got) begin
                @(negedge clk);
                if (grant != 2'b00) begin
                    got = 1;
                    cyc = k;
                    check("post-reset first winner", 32'(grant), 32'd1);
                    check("post-reset winner data", s_writedata, 32'h11);
                end
            end
        end
        if (!got) check("post-reset grant timeout", 32'd0, 32'd1);
        else check("post-reset grant latency", 32'(cyc), 32'd2);

        // Random phase against a transaction-level model.
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        owner = -1; last = 1; edges = 0;
        for (int c = 0; c < 1000; c++) begin
            logic [1:0]  e_g;
            logic        e_cs, e_wn;
            logic [1:0]  e_a;
            logic [31:0] e_wd, e_r0, e_r1;
            if (c != 0) begin
                @(posedge clk); #1;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                  $urandom);
            @(negedge clk);
            e_g = 2'b00; e_cs = 0; e_wn = 1; e_a = 0; e_wd = 0; e_r0 = 0; e_r1 = 0;
            if (owner == 0) begin
                e_g = 2'b01; e_cs = m0_chipselect; e_wn = m0_write_n;
                e_a = m0_address; e_wd = m0_writedata; e_r0 = s_readdata;
            end else if (owner == 1) begin
                e_g = 2'b10; e_cs = m1_chipselect; e_wn = m1_write_n;
                e_a = m1_address; e_wd = m1_writedata; e_r1 = s_readdata;
            end
            check("rnd grant", 32'(grant), 32'(e_g));
            check("rnd s_cs", 32'(s_chipselect), 32'(e_cs));
            check("rnd s_wn", 32'(s_write_n), 32'(e_wn));
            check("rnd s_addr", 32'(s_address), 32'(e_a));
            check("rnd s_wdata", s_writedata, e_wd);
            check("rnd m0_wait", 32'(m0_waitrequest), (owner == 0) ? 32'd0 : 32'd1);
            check("rnd m1_wait", 32'(m1_waitrequest), (owner == 1) ? 32'd0 : 32'd1);
            check("rnd m0_rdata", m0_readdata, e_r0);
            check("rnd m1_rdata", m1_readdata, e_r1);
            // Advance the model across the coming rising edge.
            if (owner >= 0) begin
                owner = -1;
            end else if (edges >= 1 && (m0_chipselect || m1_chipselect)) begin
                if (m0_chipselect && m1_chipselect) owner = 1 - last;
                else owner = m0_chipselect ? 0 : 1;
                last = owner;
            end
            edges++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
